branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-002 Parameter SHALL be: LINK_REG, default 5'd31, destination register for link writes.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode-stage instruction valid
- id_op  in  6  opcode
- id_rt  in  5  rt field (REGIMM subcode)
- id_pc  in  32  PC of branch
- id_imm  in  16  offset field
- rs_data, rt_data  in  32 each  forwarded operands
- rs_ready, rt_ready  in  1 each  operand valid (no pending hazard)
- if_ack  in  1  fetch accepted redirect
- stall_id  out  1  hold decode stage
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  branch target
- link_we  out  1  link write pulse
- link_addr  out  5  link destination
- link_data  out  32  link value
- busy  out  1  FSM not in IDLE
- br_total, br_taken  out  32 each  statistics counters

Function
REQ-004 Recognised branches SHALL be: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111; REGIMM 000001 with rt BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001; any other op or REGIMM rt SHALL be a non-branch.
REQ-005 FSM states SHALL be IDLE, WAIT, EVAL, REDIRECT.
REQ-006 In IDLE, a valid branch with all needed operands ready (BEQ/BNE: rs and rt; others: rs only) SHALL capture operands, pc, imm, and op into registers and move to EVAL next cycle.
REQ-007 In IDLE, a valid branch with a needed operand not ready SHALL move to WAIT; WAIT SHALL capture and move to EVAL in the first cycle all needed operands are ready.
REQ-008 Non-branches SHALL leave the FSM in IDLE with no output activity.
REQ-009 Conditions SHALL use signed two's-complement rs: BGEZ rs>=0, BGTZ rs>0, BLEZ rs<=0, BLTZ rs<0; BEQ/BNE bitwise equality of rs and rt.
REQ-010 Target SHALL be pc + 4 + (sign-extended imm << 2), modulo 2^32 (wrap-around permitted).
REQ-011 EVAL SHALL last one cycle: if taken, go to REDIRECT; if not taken, go to IDLE.
REQ-012 For BLTZAL/BGEZAL, link_we SHALL pulse for exactly the EVAL cycle regardless of outcome, with link_addr=LINK_REG and link_data=pc+8.
REQ-013 In REDIRECT, redirect_valid SHALL be high and redirect_pc stable until the cycle if_ack is high; the FSM SHALL return to IDLE the following cycle.
REQ-014 stall_id SHALL be high whenever state is not IDLE, and combinationally in IDLE when id_valid carries a branch with a needed operand not ready.
REQ-015 busy SHALL be high exactly when state is not IDLE.
REQ-016 id_valid SHALL be ignored outside IDLE and WAIT.

Reset
REQ-017 On rst, state SHALL become IDLE and all outputs SHALL become 0, including mid-WAIT, mid-EVAL, and mid-REDIRECT (a pending redirect or link pulse is dropped).
REQ-018 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-019 With macro BRANCH_STAT_EN defined, br_total SHALL increment in every EVAL cycle and br_taken in every taken EVAL cycle, both wrapping at 2^32 and cleared by rst.
REQ-020 Without BRANCH_STAT_EN, br_total and br_taken SHALL be constant 0 and no counter registers SHALL be synthesised.

Verification
REQ-021 BEQ, pc=0x00400000, imm=0x0004, rs=rt=5, both ready, if_ack one cycle after REDIRECT entry -> EVAL next cycle, redirect_valid with redirect_pc=0x00400014 for two cycles, then IDLE.
REQ-022 BGTZ, rs=0x80000000 -> not taken (signed), no redirect, stall_id high for the EVAL cycle only.
REQ-023 BGEZAL, rs=0xFFFFFFFF, pc=0x1000 -> not taken, link_we one pulse, link_addr=31, link_data=0x1008.
REQ-024 BNE, rt_ready low for 3 cycles -> WAIT for 3 cycles with stall_id high, EVAL on the cycle rt_ready rises.
REQ-025 BLTZ, rs=-1, pc=0xFFFFFFF0, imm=0x0003 -> redirect_pc=0x00000000 (wrap); rst asserted during REDIRECT -> redirect_valid 0 and IDLE next cycle.
REQ-026 With BRANCH_STAT_EN, 3 taken and 2 not-taken branches -> br_total=5, br_taken=3; without the macro -> both 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: resolves MIPS-style conditional branches, requests fetch redirects, and writes link registers.
// Optional build macro BRANCH_STAT_EN adds wrapping branch statistics counters (br_total, br_taken).
module branch_ctrl #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        if_ack,
  output logic        stall_id,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        busy,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] EVAL     = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  function automatic logic f_is_branch(input logic [5:0] op, input logic [4:0] rt);
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: f_is_branch = 1'b1;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: f_is_branch = 1'b1;
          default:                                f_is_branch = 1'b0;
        endcase
      end
      default: f_is_branch = 1'b0;
    endcase
  endfunction

  function automatic logic f_needs_rt(input logic [5:0] op);
    f_needs_rt = (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic f_is_link(input logic [5:0] op, input logic [4:0] rt);
    f_is_link = (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
  endfunction

  // Sign tests use bit 31 directly: rs is two's complement.
  function automatic logic f_taken(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_BEQ:  f_taken = (a == b);
      OP_BNE:  f_taken = (a != b);
      OP_BLEZ: f_taken = a[31] | (a == 32'd0);
      OP_BGTZ: f_taken = ~a[31] & (a != 32'd0);
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: f_taken = a[31];
          RT_BGEZ, RT_BGEZAL: f_taken = ~a[31];
          default:            f_taken = 1'b0;
        endcase
      end
      default: f_taken = 1'b0;
    endcase
  endfunction

  logic [1:0]  state_r, next_state_s;
  logic [5:0]  op_r;
  logic [4:0]  rtsel_r;
  logic [31:0] pc_r, rs_r, rt_r;
  logic [15:0] imm_r;
  logic        redirect_valid_r, link_we_r;
  logic [31:0] redirect_pc_r, link_data_r;
  logic [4:0]  link_addr_r;

  logic [5:0]  sel_op_s;
  logic [4:0]  sel_rtsel_s;
  logic [31:0] sel_pc_s, target_s;
  logic        id_branch_s, ops_ready_s, capture_s, taken_s;

  // In IDLE the instruction comes straight from decode; in WAIT from the held copy.
  assign sel_op_s    = (state_r == IDLE) ? id_op : op_r;
  assign sel_rtsel_s = (state_r == IDLE) ? id_rt : rtsel_r;
  assign sel_pc_s    = (state_r == IDLE) ? id_pc : pc_r;
  assign id_branch_s = id_valid & f_is_branch(id_op, id_rt);
  assign ops_ready_s = rs_ready & (rt_ready | ~f_needs_rt(sel_op_s));
  assign capture_s   = ((state_r == IDLE) & id_branch_s & ops_ready_s) |
                       ((state_r == WAIT) & ops_ready_s);
  assign taken_s     = f_taken(op_r, rtsel_r, rs_r, rt_r);
  assign target_s    = pc_r + 32'd4 + {{14{imm_r[15]}}, imm_r, 2'b00};

  // Next-state selection for the branch resolution FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (id_branch_s) begin
          if (ops_ready_s) next_state_s = EVAL;
          else             next_state_s = WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (ops_ready_s) next_state_s = EVAL;
        else             next_state_s = WAIT;
      end
      EVAL: begin
        if (taken_s) next_state_s = REDIRECT;
        else         next_state_s = IDLE;
      end
      REDIRECT: begin
        if (if_ack) next_state_s = IDLE;
        else        next_state_s = REDIRECT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, operand capture and registered redirect/link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      op_r             <= 6'd0;
      rtsel_r          <= 5'd0;
      pc_r             <= 32'd0;
      imm_r            <= 16'd0;
      rs_r             <= 32'd0;
      rt_r             <= 32'd0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      link_we_r        <= 1'b0;
      link_addr_r      <= 5'd0;
      link_data_r      <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && id_branch_s) begin
        op_r    <= id_op;
        rtsel_r <= id_rt;
        pc_r    <= id_pc;
        imm_r   <= id_imm;
      end
      if (capture_s) begin
        rs_r <= rs_data;
        rt_r <= rt_data;
      end
      // Link pulse is set up on the way into EVAL so it is visible for exactly that cycle.
      if (capture_s && f_is_link(sel_op_s, sel_rtsel_s)) begin
        link_we_r   <= 1'b1;
        link_addr_r <= LINK_REG;
        link_data_r <= sel_pc_s + 32'd8;
      end else begin
        link_we_r   <= 1'b0;
        link_addr_r <= 5'd0;
        link_data_r <= 32'd0;
      end
      if ((state_r == EVAL) && taken_s) begin
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= target_s;
      end else if ((state_r == REDIRECT) && if_ack) begin
        redirect_valid_r <= 1'b0;
        redirect_pc_r    <= 32'd0;
      end
    end
  end

  assign stall_id       = (state_r != IDLE) | (id_branch_s & ~ops_ready_s);
  assign busy           = (state_r != IDLE);
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign link_we        = link_we_r;
  assign link_addr      = link_addr_r;
  assign link_data      = link_data_r;

`ifdef BRANCH_STAT_EN
  logic [31:0] br_total_r, br_taken_r;

  // Statistics: every EVAL counts, taken EVALs also count as taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_r <= 32'd0;
      br_taken_r <= 32'd0;
    end else if (state_r == EVAL) begin
      br_total_r <= br_total_r + 32'd1;
      if (taken_s) br_taken_r <= br_taken_r + 32'd1;
    end
  end

  assign br_total = br_total_r;
  assign br_taken = br_taken_r;
`else
  assign br_total = 32'd0;
  assign br_taken = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized branches against a cycle-timeline reference model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, rs_ready, rt_ready, if_ack;
  logic [5:0]  id_op;
  logic [4:0]  id_rt;
  logic [31:0] id_pc, rs_data, rt_data;
  logic [15:0] id_imm;
  logic        stall_id, redirect_valid, link_we, busy;
  logic [31:0] redirect_pc, link_data, br_total, br_taken;
  logic [4:0]  link_addr;

  int n_assert = 0;
  int n_fail   = 0;
  int m_total  = 0;
  int m_taken  = 0;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
    .id_pc(id_pc), .id_imm(id_imm), .rs_data(rs_data), .rt_data(rt_data),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .if_ack(if_ack),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data), .busy(busy),
    .br_total(br_total), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference branch decision straight from the ISA rules, using signed integers.
  function automatic logic ref_taken(input logic [5:0] op, input logic [4:0] rtf,
                                     input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = a;
    case (op)
      6'd4:    ref_taken = (a == b);
      6'd5:    ref_taken = (a != b);
      6'd6:    ref_taken = (sa <= 0);
      6'd7:    ref_taken = (sa > 0);
      6'd1:    ref_taken = (rtf == 5'd0 || rtf == 5'd16) ? (sa < 0) : (sa >= 0);
      default: ref_taken = 1'b0;
    endcase
  endfunction

  task automatic chk_stats();
`ifdef BRANCH_STAT_EN
    chk("br_total", br_total, m_total);
    chk("br_taken", br_taken, m_taken);
`else
    chk("br_total", br_total, 32'd0);
    chk("br_taken", br_taken, 32'd0);
`endif
  endtask

  // One idle cycle with nothing offered; after a reset every output must read zero.
  task automatic idle_cycle(input logic after_rst);
    @(posedge clk); #1;
    rst = 1'b0; id_valid = 1'b0; if_ack = 1'b0;
    @(negedge clk);
    chk("idle_stall", stall_id, 32'd0);
    chk("idle_busy", busy, 32'd0);
    chk("idle_rv", redirect_valid, 32'd0);
    chk("idle_lwe", link_we, 32'd0);
    if (after_rst) begin
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_laddr", link_addr, 32'd0);
      chk("rst_ldata", link_data, 32'd0);
      chk_stats();
    end
  endtask

  // Drives one branch; the expected timeline is derived from operand/ack delays:
  // capture at cycle r (last operand ready), EVAL at r+1, then ack_dly+1 REDIRECT cycles if taken.
  task automatic run_br(input logic [5:0] op, input logic [4:0] rtf, input logic [31:0] pc,
                        input logic [15:0] imm, input logic [31:0] rsv, input logic [31:0] rtv,
                        input int rs_dly, input int rt_dly, input int ack_dly, input int rst_at);
    logic        need_rt, link, tk;
    logic [31:0] tgt;
    int          r, e, last;
    logic        did_rst;
    need_rt = (op == 6'd4) || (op == 6'd5);
    link    = (op == 6'd1) && rtf[4];
    tk      = ref_taken(op, rtf, rsv, rtv);
    tgt     = pc + 32'd4 + ({{16{imm[15]}}, imm} << 2);
    r       = (need_rt && rt_dly > rs_dly) ? rt_dly : rs_dly;
    e       = r + 1;
    last    = tk ? e + 1 + ack_dly : e;
    did_rst = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      id_valid = (c <= r) ? 1'b1 : 1'($urandom_range(0, 1));
      id_op    = op;
      id_rt    = rtf;
      id_pc    = (c <= r) ? pc : $urandom;
      id_imm   = (c <= r) ? imm : 16'($urandom);
      rs_ready = (c >= rs_dly);
      rt_ready = (c >= rt_dly);
      rs_data  = (c >= rs_dly && c <= r) ? rsv : $urandom;
      rt_data  = (c >= rt_dly && c <= r) ? rtv : $urandom;
      if_ack   = tk && (c == last);
      rst      = (c == rst_at);
      @(negedge clk);
      chk("stall", stall_id, (c > 0 || r > 0));
      chk("busy", busy, (c > 0));
      chk("rv", redirect_valid, (tk && c > e));
      if (tk && c > e) chk("rpc", redirect_pc, tgt);
      chk("lwe", link_we, (link && c == e));
      if (link && c == e) begin
        chk("laddr", link_addr, 32'd31);
        chk("ldata", link_data, pc + 32'd8);
      end
      if (c == e) begin
        m_total++;
        if (tk) m_taken++;
      end
      if (c == rst_at) begin
        did_rst = 1'b1;
        m_total = 0;
        m_taken = 0;
        break;
      end
    end
    idle_cycle(did_rst);
  endtask

  task automatic run_nb(input logic [5:0] op, input logic [4:0] rtf);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      id_valid = 1'b1; id_op = op; id_rt = rtf; id_pc = $urandom; id_imm = 16'($urandom);
      rs_ready = 1'($urandom_range(0, 1)); rt_ready = 1'($urandom_range(0, 1));
      rs_data = $urandom; rt_data = $urandom; if_ack = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("nb_stall", stall_id, 32'd0);
      chk("nb_busy", busy, 32'd0);
      chk("nb_rv", redirect_valid, 32'd0);
      chk("nb_lwe", link_we, 32'd0);
    end
  endtask

  logic [5:0]  tab_op [10] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd1, 6'd1, 6'd0, 6'd1};
  logic [4:0]  tab_rt [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd16, 5'd17, 5'd0, 5'd3};
  logic [31:0] tab_v  [6]  = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd5};

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_op = 6'd0; id_rt = 5'd0; id_pc = 32'd0; id_imm = 16'd0;
    rs_data = 32'd0; rt_data = 32'd0; rs_ready = 1'b0; rt_ready = 1'b0; if_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 32'd0);
    chk("reset_rv", redirect_valid, 32'd0);
    chk("reset_lwe", link_we, 32'd0);
    idle_cycle(1'b1);

    // BEQ taken, ack one cycle after entering REDIRECT.
    run_br(6'd4, 5'd0, 32'h00400000, 16'h0004, 32'd5, 32'd5, 0, 0, 1, -1);
    // BGTZ with most-negative rs: not taken.
    run_br(6'd7, 5'd0, 32'h00002000, 16'h0010, 32'h80000000, 32'd0, 0, 0, 0, -1);
    // BGEZAL with rs=-1: not taken but still links.
    run_br(6'd1, 5'd17, 32'h00001000, 16'h0020, 32'hFFFFFFFF, 32'd0, 0, 0, 0, -1);
    // BNE waiting three cycles for rt.
    run_br(6'd5, 5'd0, 32'h00003000, 16'hFFFC, 32'd1, 32'd2, 0, 3, 0, -1);
    // BLTZ target wraps to zero; reset lands in the first REDIRECT cycle.
    run_br(6'd1, 5'd0, 32'hFFFFFFF0, 16'h0003, 32'hFFFFFFFF, 32'd0, 0, 0, 3, 2);
    // Reset while waiting, and during EVAL of a linking branch.
    run_br(6'd4, 5'd0, 32'h00005000, 16'h0001, 32'd7, 32'd7, 0, 5, 0, 2);
    run_br(6'd1, 5'd16, 32'h00006000, 16'h0001, 32'h80000000, 32'd0, 0, 0, 0, 1);

    // Three taken, two not taken since the last reset.
    run_br(6'd4, 5'd0, 32'h100, 16'h0002, 32'd9, 32'd9, 0, 0, 0, -1);
    run_br(6'd6, 5'd0, 32'h200, 16'hFFFF, 32'd0, 32'd0, 1, 0, 2, -1);
    run_br(6'd1, 5'd1, 32'h300, 16'h0008, 32'd0, 32'd0, 0, 0, 0, -1);
    run_br(6'd5, 5'd0, 32'h400, 16'h0002, 32'd3, 32'd3, 0, 1, 0, -1);
    run_br(6'd7, 5'd0, 32'h500, 16'h0002, 32'd0, 32'd0, 2, 0, 0, -1);
    chk_stats();

    run_nb(6'd0, 5'd0);
    run_nb(6'd1, 5'd3);

    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] a, b;
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 0) ? tab_v[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 1) == 0) ? a : $urandom;
      if (k >= 8) run_nb(tab_op[k], tab_rt[k]);
      else run_br(tab_op[k], tab_rt[k], $urandom, 16'($urandom), a, b,
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), -1);
    end
    chk_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
